apb_irq_aggregator: RTL
=======================

# apb_irq_aggregator

Interrupt aggregation stage directly downstream of the APB peripheral subsystem. Consumes the subsystem's HCLK-synchronised interrupt vector (timer, dual timer, both UARTs, SPI), latches events into a pending register, applies a software enable mask, and presents one prioritised request (IRQ plus index) to the processor. Software accesses its registers through a zero-wait-state APB3 slave clocked by HCLK.

## Interface
- NUM_IRQ, 17, number of interrupt inputs, legal range 1..32
- HCLK  in  1  sole clock; all registers are updated on its rising edge
- HRESET  in  1  asynchronous, active-high reset
- IRQ_IN  in  NUM_IRQ  interrupt lines, already synchronised to HCLK
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  APB write
- PADDR  in  10  word address, PADDR[11:2]
- PWDATA  in  32  write data
- PRDATA  out  32  read data; 0 when not reading
- PREADY  out  1  tied to 1
- PSLVERR  out  1  error response
- IRQ_ACK  in  1  processor acknowledge, single-cycle pulse
- IRQ  out  1  registered request to processor
- IRQ_ID  out  5  registered index of the presented request

## Operation
- Register map, by byte offset:
  - 0x00 ENABLE: RW, reset 0.
  - 0x04 PENDING: read returns pending; a write clears each bit written as 1 (W1C).
  - 0x08 RAW: RO, current IRQ_IN.
  - 0x0C ACTIVE: RO, bit31 = IRQ, [4:0] = IRQ_ID.
  - 0x10 SWSET: WO; each bit written as 1 sets the corresponding pending bit. Reads return 0.
  - 0x14 LEVELSEL: see Configuration.
- Bits at index NUM_IRQ and above: read as zero, writes ignored.
- Writes commit on the edge where PSEL&PENABLE&PWRITE is high. Reads are combinational during the access phase.
- Unmapped offsets (0x18 and above): PSLVERR=1 in the access phase, PRDATA=0, and no state change.
- Edge detect:
  - irq_d <= IRQ_IN every cycle.
  - edge = IRQ_IN & ~irq_d.
- Pending update: pending_next = (pending & ~w1c & ~ack_clr) | edge | swset.
  - Set always wins over clear in the same cycle.
- Priority: the lowest index of (pending & ENABLE) wins.
  - IRQ <= |(pending & ENABLE).
  - IRQ_ID <= winning index, or 0 if there is none.
- Acknowledge:
  - IRQ_ACK=1 while IRQ=1 clears pending[IRQ_ID], using the registered IRQ_ID.
  - IRQ_ACK while IRQ=0 is ignored.
- Masked lines still latch pending. Setting their ENABLE bit later raises IRQ.

## Timing
- Reset values: all registers 0, including irq_d. Outputs IRQ=0, IRQ_ID=0, PRDATA=0, PSLVERR=0, PREADY=1.
- A line that is high at reset release produces an edge on the first clock.
- Latency: if IRQ_IN rises before edge k, pending is set at edge k and IRQ/IRQ_ID are valid after edge k+1.
- Disabling or clearing a bit at edge k drops IRQ after edge k+1.
- ACK at edge k: IRQ_ID moves to the next pending line, or IRQ falls, after edge k+1.
- Acknowledging a line whose new edge arrives in the same cycle leaves it pending.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock.

## Configuration
- IRQ_AGG_LEVEL_EN defined:
  - LEVELSEL is a RW register, reset 0. Bit=1 selects level mode for that line.
  - In level mode, a pending bit is set every cycle the line is high, so W1C and ACK take effect only once the line is low.
- IRQ_AGG_LEVEL_EN undefined:
  - All lines are edge mode.
  - 0x14 reads 0 and ignores writes, with no PSLVERR.

## Test plan
- Reset release with IRQ_IN=0: IRQ=0, IRQ_ID=0, every register reads 0, PREADY=1.
- ENABLE=0x1FFFF, then pulse IRQ_IN[5] and IRQ_IN[9] in the same cycle:
  - PENDING=0x220, IRQ=1, IRQ_ID=5 two edges after the input rises.
  - ACK gives IRQ_ID=9; a second ACK gives IRQ=0.
- ENABLE=0, pulse IRQ_IN[3]:
  - PENDING=0x8, IRQ stays 0.
  - Write ENABLE=0x8: IRQ=1, IRQ_ID=3 one edge later.
- Write PENDING=0x8 (W1C) in the same cycle as a new edge on line 3: bit 3 stays 1.
- Write SWSET=0x10000: IRQ_ID=16. Read offset 0x20: PSLVERR=1, PRDATA=0, no state change.
- Level mode, IRQ_AGG_LEVEL_EN defined: LEVELSEL=0x1, hold IRQ_IN[0] high:
  - ACK does not clear it and IRQ stays 1.
  - After IRQ_IN[0] falls, ACK clears it and IRQ=0.

Source files
------------

// File: rtl/apb_irq_aggregator.sv
// apb_irq_aggregator
//   Collects the APB subsystem's HCLK-synchronous interrupt lines into a
//   pending register, masks them with a software enable, and presents the
//   lowest-index enabled pending line to the processor as IRQ / IRQ_ID.
//   Registers are reached through a zero-wait-state APB3 slave.
//
// Ports
//   HCLK, HRESET          clock, asynchronous active-high reset
//   IRQ_IN[NUM_IRQ-1:0]   interrupt lines (already in the HCLK domain)
//   PSEL/PENABLE/PWRITE   APB control
//   PADDR[9:0]            word address (byte address bits 11:2)
//   PWDATA/PRDATA         APB write / read data (PRDATA is 0 unless reading)
//   PREADY, PSLVERR       always ready; error on unmapped offsets
//   IRQ_ACK               processor acknowledge pulse
//   IRQ, IRQ_ID           registered request and its line index
//
// Register map (byte offset)
//   0x00 ENABLE  RW     0x04 PENDING  R / W1C    0x08 RAW     RO
//   0x0C ACTIVE  RO     0x10 SWSET    WO (W1S)   0x14 LEVELSEL
//
// Build option
//   IRQ_AGG_LEVEL_EN  when defined, LEVELSEL is a RW register selecting
//                     level-sensitive pending per line; otherwise every line
//                     is edge-sensitive and 0x14 reads as zero.

module apb_irq_aggregator #(
  parameter int unsigned NUM_IRQ = 17
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic [NUM_IRQ-1:0] IRQ_IN,
  input  logic               PSEL,
  input  logic               PENABLE,
  input  logic               PWRITE,
  input  logic [9:0]         PADDR,
  input  logic [31:0]        PWDATA,
  output logic [31:0]        PRDATA,
  output logic               PREADY,
  output logic               PSLVERR,
  input  logic               IRQ_ACK,
  output logic               IRQ,
  output logic [4:0]         IRQ_ID
);

  typedef enum logic [9:0] {
    REG_ENABLE   = 10'd0,
    REG_PENDING  = 10'd1,
    REG_RAW      = 10'd2,
    REG_ACTIVE   = 10'd3,
    REG_SWSET    = 10'd4,
    REG_LEVELSEL = 10'd5
  } reg_addr_e;

  function automatic logic [31:0] widen(input logic [NUM_IRQ-1:0] v);
    widen = '0;
    widen[NUM_IRQ-1:0] = v;
  endfunction

  logic [NUM_IRQ-1:0] irq_d;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] enable_r;
  logic [NUM_IRQ-1:0] pending_next;
  logic [NUM_IRQ-1:0] edge_det;
  logic [NUM_IRQ-1:0] level_set;
  logic [NUM_IRQ-1:0] w1c;
  logic [NUM_IRQ-1:0] swset;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [NUM_IRQ-1:0] masked;
  logic [NUM_IRQ-1:0] wdata_n;
  logic               access;
  logic               wr_en;
  logic               rd_en;
  logic               addr_ok;
  logic               win_found;
  logic [4:0]         win_id;
  logic [31:0]        rdata;
  logic               unused_pwdata;

  assign access   = PSEL & PENABLE;
  assign wr_en    = access & PWRITE & addr_ok;
  assign rd_en    = access & ~PWRITE;
  assign addr_ok  = (PADDR <= REG_LEVELSEL);
  assign wdata_n  = PWDATA[NUM_IRQ-1:0];
  assign unused_pwdata = ^PWDATA;

  assign PREADY   = 1'b1;
  assign PSLVERR  = access & ~addr_ok;

  assign edge_det = IRQ_IN & ~irq_d;
  assign masked   = pending & enable_r;
  assign w1c      = (wr_en && PADDR == REG_PENDING) ? wdata_n : '0;
  assign swset    = (wr_en && PADDR == REG_SWSET)   ? wdata_n : '0;

`ifdef IRQ_AGG_LEVEL_EN
  logic [NUM_IRQ-1:0] levelsel_r;

  // A level-mode line re-asserts pending every cycle it is high, so any
  // W1C or ACK clear is overridden until the line drops.
  assign level_set = IRQ_IN & levelsel_r;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)
      levelsel_r <= '0;
    else if (wr_en && PADDR == REG_LEVELSEL)
      levelsel_r <= wdata_n;
  end
`else
  assign level_set = '0;
`endif

  // Acknowledge targets the registered IRQ_ID, not the live winner.
  always_comb begin
    ack_clr = '0;
    if (IRQ_ACK && IRQ) begin
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
        if (IRQ_ID == 5'(i))
          ack_clr[i] = 1'b1;
      end
    end
  end

  // Sets are OR-ed in last so they win over clears in the same cycle.
  assign pending_next = (pending & ~w1c & ~ack_clr) | edge_det | swset | level_set;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (masked[i] && !win_found) begin
        win_found = 1'b1;
        win_id    = 5'(i);
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      irq_d    <= '0;
      pending  <= '0;
      enable_r <= '0;
      IRQ      <= 1'b0;
      IRQ_ID   <= '0;
    end else begin
      irq_d   <= IRQ_IN;
      pending <= pending_next;
      if (wr_en && PADDR == REG_ENABLE)
        enable_r <= wdata_n;
      IRQ    <= win_found;
      IRQ_ID <= win_id;
    end
  end

  always_comb begin
    rdata = '0;
    case (PADDR)
      REG_ENABLE:   rdata = widen(enable_r);
      REG_PENDING:  rdata = widen(pending);
      REG_RAW:      rdata = widen(IRQ_IN);
      REG_ACTIVE:   rdata = {IRQ, 26'd0, IRQ_ID};
`ifdef IRQ_AGG_LEVEL_EN
      REG_LEVELSEL: rdata = widen(levelsel_r);
`endif
      default:      rdata = '0;
    endcase
  end

  assign PRDATA = rd_en ? rdata : '0;

endmodule
